// File: rtl/id_stage.sv
// id_stage: instruction decode with busy scoreboard, RAW/WAW stall and one-entry output register
// Optional feature macro ID_ILLEGAL_TRAP_EN: opcode 11x is accepted but dropped and sets sticky illegal_op;
// otherwise 11x decodes as a NOP bundle and illegal_op stays 0.
// Ports: clk/reset (sync, active-high); fetch side in_valid/in_ready/in_instr/in_pc;
//        RF read RS/RT -> rf_rd1/rf_rd2; writeback mirror wb_we/wb_rd; flush;
//        execute side out_valid/out_ready and the out_* bundle; busy_vec scoreboard; illegal_op.
module id_stage #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3,
    parameter int NUM_REGS   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_instr,
    input  logic [DATA_W-1:0]     in_pc,
    output logic [REG_ADDR_W-1:0] RS,
    output logic [REG_ADDR_W-1:0] RT,
    input  logic [DATA_W-1:0]     rf_rd1,
    input  logic [DATA_W-1:0]     rf_rd2,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            out_alu_op,
    output logic                  out_reg_we,
    output logic                  out_mem_rd,
    output logic                  out_mem_wr,
    output logic                  out_branch,
    output logic                  out_jump,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [DATA_W-1:0]     out_a,
    output logic [DATA_W-1:0]     out_b,
    output logic [DATA_W-1:0]     out_imm,
    output logic [DATA_W-1:0]     out_pc,
    output logic [NUM_REGS-1:0]   busy_vec,
    output logic                  illegal_op
);
`ifdef ID_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    logic [2:0]            op;
    logic                  is_r, is_addi, is_lw, is_sw, is_beq, is_j, is_ill;
    logic [REG_ADDR_W-1:0] dest;
    logic                  wr, use_rs, use_rt, hazard, accept;
    logic [NUM_REGS-1:0]   wb_mask, pend, busy_q, busy_d;
    logic [DATA_W-1:0]     imm;
    logic [3:0]            alu;
    logic                  valid_q, valid_d, ill_q, ill_d;
    logic [3:0]            alu_q;
    logic                  we_q, mr_q, mw_q, br_q, j_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0]     a_q, b_q, imm_q, pc_q;

    assign op      = in_instr[15:13];
    assign is_r    = op == 3'b000;
    assign is_addi = op == 3'b001;
    assign is_lw   = op == 3'b010;
    assign is_sw   = op == 3'b011;
    assign is_beq  = op == 3'b100;
    assign is_j    = op == 3'b101;
    assign is_ill  = op[2:1] == 2'b11;
    assign RS      = in_instr[12:10];
    assign RT      = in_instr[9:7];
    assign dest    = is_r ? in_instr[6:4] : in_instr[9:7];
    // r0 is hardwired zero: writes to it are dropped and never tracked
    assign wr      = (is_r || is_addi || is_lw) && dest != '0;
    assign use_rs  = !(is_j || is_ill);
    assign use_rt  = is_r || is_sw || is_beq;
    // RF writes on the falling edge, so a same-cycle writeback already satisfies a source read
    assign wb_mask = wb_we ? NUM_REGS'(1) << wb_rd : '0;
    assign pend    = busy_q & ~wb_mask & ~NUM_REGS'(1);
    assign hazard  = (use_rs && pend[RS]) || (use_rt && pend[RT]) || (wr && busy_q[dest]);
    assign in_ready = !reset && !flush && !hazard && (!valid_q || out_ready);
    assign accept  = in_valid && in_ready;
    assign alu     = is_r ? in_instr[3:0] : is_beq ? 4'b0001 : 4'b0000;
    assign imm     = is_j ? {{(DATA_W-13){1'b0}}, in_instr[12:0]} :
                     (is_addi || is_lw || is_sw || is_beq) ? {{(DATA_W-7){in_instr[6]}}, in_instr[6:0]} : '0;

    always_comb begin
        busy_d = busy_q & ~wb_mask;
        if (flush && valid_q && we_q) busy_d[rd_q] = 1'b0;
        if (accept && wr) busy_d[dest] = 1'b1;
        valid_d = flush ? 1'b0 : accept ? !(TRAP && is_ill) : valid_q && !out_ready;
        ill_d   = ill_q || (TRAP && accept && is_ill);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            busy_q  <= '0;
            ill_q   <= 1'b0;
            alu_q   <= '0;
            we_q    <= 1'b0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            br_q    <= 1'b0;
            j_q     <= 1'b0;
            rd_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ill_q   <= ill_d;
            if (accept) begin
                alu_q <= alu;
                we_q  <= wr;
                mr_q  <= is_lw;
                mw_q  <= is_sw;
                br_q  <= is_beq;
                j_q   <= is_j;
                rd_q  <= wr ? dest : '0;
                a_q   <= rf_rd1;
                b_q   <= rf_rd2;
                imm_q <= imm;
                pc_q  <= in_pc;
            end
        end
    end

    assign out_valid  = valid_q;
    assign out_alu_op = alu_q;
    assign out_reg_we = we_q;
    assign out_mem_rd = mr_q;
    assign out_mem_wr = mw_q;
    assign out_branch = br_q;
    assign out_jump   = j_q;
    assign out_rd     = rd_q;
    assign out_a      = a_q;
    assign out_b      = b_q;
    assign out_imm    = imm_q;
    assign out_pc     = pc_q;
    assign busy_vec   = busy_q;
    assign illegal_op = ill_q;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed and random stimulus for id_stage, checked every cycle against a behavioural model
module tb_id_stage;
`ifdef ID_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, wb_we, flush, out_valid, out_ready;
    logic [15:0] in_instr, in_pc, rf_rd1, rf_rd2;
    logic [2:0]  RS, RT, wb_rd, out_rd;
    logic [3:0]  out_alu_op;
    logic        out_reg_we, out_mem_rd, out_mem_wr, out_branch, out_jump, illegal_op;
    logic [15:0] out_a, out_b, out_imm, out_pc;
    logic [7:0]  busy_vec;

    id_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .RS(RS), .RT(RT),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .wb_we(wb_we), .wb_rd(wb_rd), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_alu_op(out_alu_op),
        .out_reg_we(out_reg_we), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
        .out_branch(out_branch), .out_jump(out_jump), .out_rd(out_rd),
        .out_a(out_a), .out_b(out_b), .out_imm(out_imm), .out_pc(out_pc),
        .busy_vec(busy_vec), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [3:0]  alu;
        logic        we, mr, mw, br, j;
        logic [2:0]  rd;
        logic [15:0] imm;
    } dec_t;

    // Decode straight from the instruction-set table
    function automatic dec_t decode(input logic [15:0] x);
        dec_t d;
        logic [15:0] sx;
        d  = '0;
        sx = {{9{x[6]}}, x[6:0]};
        case (x[15:13])
            3'd0: begin d.alu = x[3:0]; d.rd = x[6:4]; end
            3'd1: begin d.rd = x[9:7]; d.imm = sx; end
            3'd2: begin d.rd = x[9:7]; d.imm = sx; d.mr = 1'b1; end
            3'd3: begin d.imm = sx; d.mw = 1'b1; end
            3'd4: begin d.imm = sx; d.alu = 4'd1; d.br = 1'b1; end
            3'd5: begin d.imm = {3'b000, x[12:0]}; d.j = 1'b1; end
            default: ;
        endcase
        d.we = (x[15:13] <= 3'd2) && d.rd != 3'd0;
        if (!d.we) d.rd = 3'd0;
        return d;
    endfunction

    bit          m_busy [8];
    bit          m_valid, m_ill, started;
    dec_t        m_d;
    logic [15:0] m_a, m_b, m_pc;

    function automatic logic [7:0] m_busy_vec();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic bit blocked(input logic [2:0] s);
        return s != 3'd0 && m_busy[s] && !(wb_we && wb_rd == s);
    endfunction

    function automatic bit exp_ready();
        logic [2:0] op;
        dec_t       d;
        bit         haz;
        op  = in_instr[15:13];
        d   = decode(in_instr);
        haz = (op <= 3'd4 && blocked(in_instr[12:10]))
           || ((op == 3'd0 || op == 3'd3 || op == 3'd4) && blocked(in_instr[9:7]))
           || (d.we && m_busy[d.rd]);
        return !reset && !flush && !haz && (!m_valid || out_ready);
    endfunction

    always @(posedge clk) begin
        bit   acc, ill;
        dec_t d;
        if (reset) begin
            m_valid = 0; m_ill = 0; m_d = '0; m_a = '0; m_b = '0; m_pc = '0;
            for (int i = 0; i < 8; i++) m_busy[i] = 0;
            started = 1;
        end else begin
            acc = in_valid && exp_ready();
            d   = decode(in_instr);
            ill = in_instr[15:14] == 2'b11;
            if (wb_we) m_busy[wb_rd] = 0;
            if (flush && m_valid && m_d.we) m_busy[m_d.rd] = 0;
            if (acc && d.we) m_busy[d.rd] = 1;
            if (flush) m_valid = 0;
            else if (acc) begin
                m_valid = !(TRAP && ill);
                m_d = d; m_a = rf_rd1; m_b = rf_rd2; m_pc = in_pc;
                if (TRAP && ill) m_ill = 1;
            end else if (out_ready) m_valid = 0;
        end
    end

    always @(negedge clk) begin
        if (started && !reset) begin
            check("in_ready", in_ready, exp_ready());
            check("out_valid", out_valid, m_valid);
            check("busy_vec", busy_vec, m_busy_vec());
            check("illegal_op", illegal_op, m_ill);
            check("RS", RS, in_instr[12:10]);
            check("RT", RT, in_instr[9:7]);
            if (m_valid) begin
                check("out_alu_op", out_alu_op, m_d.alu);
                check("out_reg_we", out_reg_we, m_d.we);
                check("out_mem_rd", out_mem_rd, m_d.mr);
                check("out_mem_wr", out_mem_wr, m_d.mw);
                check("out_branch", out_branch, m_d.br);
                check("out_jump", out_jump, m_d.j);
                check("out_rd", out_rd, m_d.rd);
                check("out_imm", out_imm, m_d.imm);
                check("out_a", out_a, m_a);
                check("out_b", out_b, m_b);
                check("out_pc", out_pc, m_pc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [2:0] r);
        wb_we = 1; wb_rd = r;
        step();
        wb_we = 0;
    endtask

    logic [15:0] mix [3];

    initial begin
        reset = 1; in_valid = 0; out_ready = 1; wb_we = 0; wb_rd = 0; flush = 0;
        in_instr = 0; in_pc = 0; rf_rd1 = 0; rf_rd2 = 0;
        repeat (2) step();
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy_vec, 8'h00);
        check("rst_imm", out_imm, 0);
        check("rst_a", out_a, 0);
        check("rst_ctrl", {out_alu_op, out_reg_we, out_mem_rd, out_mem_wr, out_branch, out_jump, out_rd}, 0);
        check("rst_illegal", illegal_op, 0);
        reset = 0;
        #1;
        check("rst_in_ready", in_ready, 1);

        // ADDI r2,r1,-3
        in_instr = 16'h257D; rf_rd1 = 16'h0010; rf_rd2 = 16'h1234; in_pc = 16'h0100; in_valid = 1;
        #1;
        check("addi_RS", RS, 3'd1);
        check("addi_RT", RT, 3'd2);
        step();
        in_valid = 0;
        check("addi_valid", out_valid, 1);
        check("addi_imm", out_imm, 16'hFFFD);
        check("addi_rd", out_rd, 3'd2);
        check("addi_we", out_reg_we, 1);
        check("addi_a", out_a, 16'h0010);
        check("addi_pc", out_pc, 16'h0100);
        check("addi_busy", busy_vec, 8'h04);
        wb(3'd2);
        check("addi_wb_busy", busy_vec, 8'h00);

        // stale writeback to r2 in the same cycle r2 is claimed: set wins
        in_instr = 16'h257D; in_valid = 1; wb_we = 1; wb_rd = 3'd2;
        step();
        in_valid = 0; wb_we = 0;
        check("set_wins_busy", busy_vec, 8'h04);
        wb(3'd2);

        // LW r3 then ADD r4,r3,r1
        in_instr = 16'h4580; in_valid = 1;
        step();
        check("lw_busy", busy_vec, 8'h08);
        in_instr = 16'h0CC0;
        #1;
        repeat (3) begin
            check("raw_stall", in_ready, 0);
            step();
        end
        wb_we = 1; wb_rd = 3'd3;
        #1;
        check("raw_wb_ready", in_ready, 1);
        step();
        in_valid = 0; wb_we = 0;
        check("raw_busy", busy_vec, 8'h10);
        check("raw_valid", out_valid, 1);
        check("raw_rd", out_rd, 3'd4);
        wb(3'd4);

        // back-pressure: ADD r5 held for 3 cycles, ADD r6 waiting
        out_ready = 0; in_instr = 16'h0552; in_valid = 1;
        step();
        in_instr = 16'h0563;
        #1;
        repeat (3) begin
            check("stall_rd", out_rd, 3'd5);
            check("stall_alu", out_alu_op, 4'd2);
            check("stall_ready", in_ready, 0);
            step();
        end
        out_ready = 1;
        #1;
        check("release_ready", in_ready, 1);
        step();
        in_valid = 0;
        check("release_rd", out_rd, 3'd6);
        check("release_alu", out_alu_op, 4'd3);
        check("release_busy", busy_vec, 8'h60);
        step();
        wb(3'd5);
        wb(3'd6);

        // flush a held ADD r5 while ADD r6 waits
        out_ready = 0; in_instr = 16'h0552; in_valid = 1;
        step();
        check("flush_pre_busy", busy_vec, 8'h20);
        in_instr = 16'h0563; flush = 1;
        #1;
        check("flush_ready", in_ready, 0);
        step();
        flush = 0; in_valid = 0;
        check("flush_valid", out_valid, 0);
        check("flush_busy", busy_vec, 8'h00);
        out_ready = 1;

        // reset (with flush) in the middle of a stall
        out_ready = 0; in_instr = 16'h0552; in_valid = 1;
        step();
        in_valid = 0; flush = 1; reset = 1;
        step();
        check("rst_stall_valid", out_valid, 0);
        check("rst_stall_busy", busy_vec, 8'h00);
        check("rst_stall_ready", in_ready, 0);
        reset = 0; flush = 0; out_ready = 1;
        #1;
        check("rst_stall_ready2", in_ready, 1);

        // illegal opcode
        in_instr = 16'hE000; in_valid = 1;
        step();
        in_valid = 0;
        if (TRAP) begin
            check("ill_flag", illegal_op, 1);
            check("ill_valid", out_valid, 0);
        end else begin
            check("nop_flag", illegal_op, 0);
            check("nop_valid", out_valid, 1);
            check("nop_we", out_reg_we, 0);
        end
        step();

        // BEQ r1,r2,-1 ; SW r2,5(r1) ; J 0x1ABC back-to-back
        mix[0] = 16'h857F; mix[1] = 16'h6505; mix[2] = 16'hBABC;
        for (int i = 0; i < 3; i++) begin
            in_instr = mix[i]; rf_rd1 = 16'(i * 16'h111); rf_rd2 = 16'(16'hA000 + i); in_pc = 16'(16'h0200 + 2 * i);
            in_valid = 1;
            step();
        end
        in_valid = 0;
        check("j_imm", out_imm, 16'h1ABC);
        check("j_jump", out_jump, 1);
        step();

        // random traffic, model-checked every cycle
        for (int i = 0; i < 300; i++) begin
            in_instr  = 16'($urandom);
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            wb_we     = 1'($urandom);
            wb_rd     = 3'($urandom);
            flush     = ($urandom_range(0, 7) == 0);
            rf_rd1    = 16'($urandom);
            rf_rd2    = 16'($urandom);
            in_pc     = 16'($urandom);
            step();
        end
        in_valid = 0; wb_we = 0; flush = 0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
